// File: rtl/uart_cmd_parser.sv
// Frames UART command packets (SYNC, CMD, LEN, payload, CHK), buffers and checksums the
// payload, and holds each validated packet until the consumer acknowledges it.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         MAX_LEN      = 16,
  parameter int         ADDR_W       = 4,
  parameter int         TIMEOUT_CLKS = 1041600
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Rx_DV,
  input  logic [7:0]        i_Rx_Byte,
  output logic              o_Pkt_Valid,
  output logic [7:0]        o_Pkt_Cmd,
  output logic [ADDR_W:0]   o_Pkt_Len,
  input  logic              i_Pkt_Ack,
  input  logic [ADDR_W-1:0] i_Rd_Addr,
  output logic [7:0]        o_Rd_Data,
  output logic              o_Err,
  output logic [1:0]        o_Err_Code,
  output logic [7:0]        o_Err_Count
);

  localparam int                LEN_W     = ADDR_W + 1;
  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [8:0]        MAX_LEN_W = 9'(MAX_LEN);
  localparam logic [20:0]       TMO_LAST  = 21'(TIMEOUT_CLKS - 1);
  localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);

  localparam logic [1:0] ERR_LEN = 2'd1;
  localparam logic [1:0] ERR_CHK = 2'd2;
  localparam logic [1:0] ERR_TMO = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_CMD  = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_HOLD = 3'd5
  } state_e;

  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    if (c == 8'hFF) begin
      return c;
    end else begin
      return c + 8'd1;
    end
  endfunction

  state_e             state_q, state_d;
  logic [7:0]         cmd_q, cmd_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [7:0]         sum_q, sum_d;
  logic [20:0]        tmo_q, tmo_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [1:0]         code_q, code_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         rd_data_q;
  logic               wr_en_s;
  logic               timing_s;
  logic [7:0]         mem_q [DEPTH];

  // Next-state and datapath decode for the framing FSM.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    len_d    = len_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    tmo_d    = tmo_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    code_d   = code_q;
    cnt_d    = cnt_q;
    wr_en_s  = 1'b0;
    timing_s = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = ST_CMD;
        end else begin
          state_d = ST_HUNT;
        end
      end
      ST_CMD: begin
        timing_s = 1'b1;
        if (i_Rx_DV) begin
          cmd_d   = i_Rx_Byte;
          sum_d   = i_Rx_Byte;
          state_d = ST_LEN;
        end else begin
          state_d = ST_CMD;
        end
      end
      ST_LEN: begin
        timing_s = 1'b1;
        if (i_Rx_DV) begin
          sum_d = add8(sum_q, i_Rx_Byte);
          if ({1'b0, i_Rx_Byte} > MAX_LEN_W) begin
            state_d = ST_HUNT;
            err_d   = 1'b1;
            code_d  = ERR_LEN;
            cnt_d   = sat_inc8(cnt_q);
          end else if (i_Rx_Byte == 8'd0) begin
            len_d   = '0;
            state_d = ST_CHK;
          end else begin
            len_d   = LEN_W'(i_Rx_Byte);
            idx_d   = '0;
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_LEN;
        end
      end
      ST_DATA: begin
        timing_s = 1'b1;
        if (i_Rx_DV) begin
          wr_en_s = 1'b1;
          sum_d   = add8(sum_q, i_Rx_Byte);
          if (LEN_W'(idx_q) == (len_q - LEN_ONE)) begin
            state_d = ST_CHK;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_CHK: begin
        timing_s = 1'b1;
        if (i_Rx_DV) begin
          if (i_Rx_Byte == sum_q) begin
            state_d = ST_HOLD;
            valid_d = 1'b1;
          end else begin
            state_d = ST_HUNT;
            err_d   = 1'b1;
            code_d  = ERR_CHK;
            cnt_d   = sat_inc8(cnt_q);
          end
        end else begin
          state_d = ST_CHK;
        end
      end
      ST_HOLD: begin
        // Bytes arriving while a packet is held are counted but never parsed.
        if (i_Rx_DV) begin
          cnt_d = sat_inc8(cnt_q);
        end else begin
          cnt_d = cnt_q;
        end
        if (i_Pkt_Ack) begin
          state_d = ST_HUNT;
          valid_d = 1'b0;
        end else begin
          state_d = ST_HOLD;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_HUNT;
      end
    endcase

    // Inter-byte watchdog only runs while a frame is in progress.
    if (timing_s) begin
      if (i_Rx_DV) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_LAST) begin
        tmo_d   = '0;
        state_d = ST_HUNT;
        err_d   = 1'b1;
        code_d  = ERR_TMO;
        cnt_d   = sat_inc8(cnt_q);
      end else begin
        tmo_d = tmo_q + 21'd1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  // Control and status registers.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_HUNT;
      cmd_q   <= 8'd0;
      len_q   <= '0;
      idx_q   <= '0;
      sum_q   <= 8'd0;
      tmo_q   <= 21'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 2'd0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      tmo_q   <= tmo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
    end
  end

  // Payload buffer write port; contents are not reset.
  always_ff @(posedge i_Clock) begin
    if (wr_en_s) begin
      mem_q[idx_q] <= i_Rx_Byte;
    end
  end

  // Registered payload read port.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rd_data_q <= 8'd0;
    end else begin
      rd_data_q <= mem_q[i_Rd_Addr];
    end
  end

  assign o_Pkt_Valid = valid_q;
  assign o_Pkt_Cmd   = cmd_q;
  assign o_Pkt_Len   = len_q;
  assign o_Rd_Data   = rd_data_q;
  assign o_Err       = err_q;
  assign o_Err_Code  = code_q;
  assign o_Err_Count = cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Bench for uart_cmd_parser: directed scenarios plus random frames checked against a
// packet-level reference model.
module tb_uart_cmd_parser;

  localparam int TMO  = 64;
  localparam int MAXL = 16;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       i_Clock = 1'b0;
  logic       i_Reset = 1'b1;
  logic       i_Rx_DV = 1'b0;
  logic [7:0] i_Rx_Byte = 8'd0;
  logic       i_Pkt_Ack = 1'b0;
  logic [3:0] i_Rd_Addr = 4'd0;
  logic       o_Pkt_Valid;
  logic [7:0] o_Pkt_Cmd;
  logic [4:0] o_Pkt_Len;
  logic [7:0] o_Rd_Data;
  logic       o_Err;
  logic [1:0] o_Err_Code;
  logic [7:0] o_Err_Count;

  int errors = 0;
  int checks = 0;
  int pulse_cnt = 0;
  int exp_cnt = 0;
  int exp_code = 0;
  int exp_pulses = 0;
  logic [7:0] pay_q[$];

  uart_cmd_parser #(
    .SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .ADDR_W(4), .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock(i_Clock), .i_Reset(i_Reset), .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
    .o_Pkt_Valid(o_Pkt_Valid), .o_Pkt_Cmd(o_Pkt_Cmd), .o_Pkt_Len(o_Pkt_Len),
    .i_Pkt_Ack(i_Pkt_Ack), .i_Rd_Addr(i_Rd_Addr), .o_Rd_Data(o_Rd_Data),
    .o_Err(o_Err), .o_Err_Code(o_Err_Code), .o_Err_Count(o_Err_Count)
  );

  always #5 i_Clock = ~i_Clock;

  // Counts cycles on which the error pulse is high.
  always @(posedge i_Clock) begin
    if (o_Err === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [7:0] good_chk(input logic [7:0] cmd, input logic [7:0] len);
    int s;
    s = cmd + len;
    foreach (pay_q[i]) s += pay_q[i];
    return 8'(s % 256);
  endfunction

  // Called at a falling edge; returns at the falling edge after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    i_Rx_DV = 1'b1;
    i_Rx_Byte = b;
    @(negedge i_Clock);
    i_Rx_DV = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge i_Clock);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len,
                            input logic [7:0] chk, input int junk);
    logic [7:0] j;
    for (int k = 0; k < junk; k++) begin
      j = 8'($urandom);
      if (j == SYNC) j = 8'h00;
      send_byte(j);
      gap($urandom_range(0, 3));
    end
    send_byte(SYNC);
    gap($urandom_range(0, 3));
    send_byte(cmd);
    gap($urandom_range(0, 3));
    send_byte(len);
    if (len <= MAXL) begin
      foreach (pay_q[i]) begin
        gap($urandom_range(0, 3));
        send_byte(pay_q[i]);
      end
      gap($urandom_range(0, 3));
      send_byte(chk);
    end
  endtask

  task automatic expect_err(input string tag, input int code);
    exp_code = code;
    exp_cnt = sat(exp_cnt + 1);
    exp_pulses++;
    check({tag, "_err"}, o_Err, 1);
    check({tag, "_code"}, o_Err_Code, code);
    check({tag, "_cnt"}, o_Err_Count, exp_cnt);
    check({tag, "_novalid"}, o_Pkt_Valid, 0);
  endtask

  task automatic expect_pkt(input string tag, input logic [7:0] cmd, input int len);
    check({tag, "_valid"}, o_Pkt_Valid, 1);
    check({tag, "_cmd"}, o_Pkt_Cmd, cmd);
    check({tag, "_len"}, o_Pkt_Len, len);
    check({tag, "_cnt"}, o_Err_Count, exp_cnt);
    for (int i = 0; i < len; i++) begin
      i_Rd_Addr = 4'(i);
      @(negedge i_Clock);
      check({tag, "_data"}, o_Rd_Data, pay_q[i]);
    end
  endtask

  task automatic do_ack(input string tag);
    i_Pkt_Ack = 1'b1;
    @(negedge i_Clock);
    i_Pkt_Ack = 1'b0;
    check({tag, "_released"}, o_Pkt_Valid, 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, o_Pkt_Valid, 0);
    check({tag, "_cmd"}, o_Pkt_Cmd, 0);
    check({tag, "_len"}, o_Pkt_Len, 0);
    check({tag, "_rd"}, o_Rd_Data, 0);
    check({tag, "_err"}, o_Err, 0);
    check({tag, "_code"}, o_Err_Code, 0);
    check({tag, "_cnt"}, o_Err_Count, 0);
  endtask

  task automatic load_pay(input int n);
    pay_q.delete();
    for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
  endtask

  initial begin
    int seen;
    int when;
    int kind;
    int n;
    logic [7:0] c;
    logic [7:0] l;

    // Reset state
    gap(3);
    check_zero("reset");
    i_Reset = 1'b0;
    gap(2);

    // 1: basic three-byte packet, then idle in HOLD past the watchdog period
    pay_q = '{8'h01, 8'h02, 8'h03};
    send_frame(8'h10, 8'h03, 8'h19, 0);
    expect_pkt("t1", 8'h10, 3);
    gap(TMO + 10);
    check("t1_hold_idle", o_Pkt_Valid, 1);
    do_ack("t1");

    // 2: zero-length packet, then a bad checksum
    pay_q.delete();
    send_frame(8'h22, 8'h00, 8'h22, 1);
    expect_pkt("t2a", 8'h22, 0);
    do_ack("t2a");
    send_frame(8'h22, 8'h00, 8'h23, 0);
    expect_err("t2b", 2);
    @(negedge i_Clock);
    check("t2b_pulse_end", o_Err, 0);

    // 3: length over maximum, then recovery
    send_frame(8'h01, 8'h11, 8'h00, 0);
    expect_err("t3a", 1);
    pay_q.delete();
    send_frame(8'h01, 8'h00, 8'h01, 0);
    expect_pkt("t3b", 8'h01, 0);
    do_ack("t3b");

    // 4: inter-byte timeout
    send_byte(SYNC);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h05);
    seen = 0;
    when = 0;
    for (int k = 1; k <= TMO + 4; k++) begin
      if (seen == 0) begin
        @(negedge i_Clock);
        if (o_Err === 1'b1) begin
          seen = 1;
          when = k;
        end
      end
    end
    check("t4_seen", seen, 1);
    check("t4_not_early", (when >= TMO - 2) ? 1 : 0, 1);
    expect_err("t4", 3);
    load_pay(2);
    send_frame(8'h44, 8'h02, good_chk(8'h44, 8'h02), 0);
    expect_pkt("t4b", 8'h44, 2);

    // 5: bytes dropped while holding, including one on the ack cycle (a SYNC)
    for (int k = 0; k < 3; k++) begin
      send_byte(8'($urandom));
      exp_cnt = sat(exp_cnt + 1);
      gap($urandom_range(0, 2));
    end
    expect_pkt("t5", 8'h44, 2);
    i_Pkt_Ack = 1'b1;
    send_byte(SYNC);
    i_Pkt_Ack = 1'b0;
    exp_cnt = sat(exp_cnt + 1);
    check("t5_ack_valid", o_Pkt_Valid, 0);
    check("t5_ack_cnt", o_Err_Count, exp_cnt);
    check("t5_code_kept", o_Err_Code, exp_code);
    load_pay(1);
    send_frame(8'h55, 8'h01, good_chk(8'h55, 8'h01), 0);
    expect_pkt("t5b", 8'h55, 1);

    // Saturation of the error counter
    for (int k = 0; k < 260; k++) begin
      send_byte(8'($urandom));
      exp_cnt = sat(exp_cnt + 1);
    end
    check("sat_cnt", o_Err_Count, 255);
    expect_pkt("sat", 8'h55, 1);
    do_ack("sat");

    // 6: reset in DATA and in HOLD
    send_byte(SYNC);
    send_byte(8'h66);
    send_byte(8'h05);
    send_byte(8'h11);
    #2 i_Reset = 1'b1;
    #1 check_zero("rst_data");
    @(negedge i_Clock);
    i_Reset = 1'b0;
    exp_cnt = 0;
    exp_code = 0;
    load_pay(4);
    send_frame(8'h67, 8'h04, good_chk(8'h67, 8'h04), 0);
    expect_pkt("rst_a", 8'h67, 4);
    #2 i_Reset = 1'b1;
    #1 check_zero("rst_hold");
    @(negedge i_Clock);
    i_Reset = 1'b0;
    load_pay(5);
    send_frame(8'h68, 8'h05, good_chk(8'h68, 8'h05), 1);
    expect_pkt("rst_b", 8'h68, 5);
    do_ack("rst_b");

    // Random frames
    for (int f = 0; f < 25; f++) begin
      kind = $urandom_range(0, 3);
      c = 8'($urandom);
      if (kind == 2) begin
        l = 8'($urandom_range(MAXL + 1, 255));
        pay_q.delete();
        send_frame(c, l, 8'h00, $urandom_range(0, 2));
        expect_err("rnd_len", 1);
      end else begin
        n = $urandom_range(0, MAXL);
        l = 8'(n);
        load_pay(n);
        if (kind == 3) begin
          send_frame(c, l, good_chk(c, l) + 8'd1, $urandom_range(0, 2));
          expect_err("rnd_chk", 2);
        end else begin
          send_frame(c, l, good_chk(c, l), $urandom_range(0, 2));
          expect_pkt("rnd_pkt", c, n);
          do_ack("rnd_pkt");
        end
      end
    end

    gap(3);
    check("pulse_total", pulse_cnt, exp_pulses);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
